cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits directly downstream of the eviction write buffer.
- Converts one 256-bit cache-line request (read or write) into a 4-beat 64-bit burst transaction on the physical memory bus.
- Presents one line-wide response back upstream.
- Single transaction in flight; no queuing.

Parameters:
LINE_W, 256, cache line width in bits.
BURST_W, 64, memory bus beat width in bits; BEATS = LINE_W/BURST_W (must divide exactly; 4 by default).
TIMEOUT_CYCLES, 1024, idle-beat limit before abort (used only with optional feature).

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  reset, asynchronous, active-low.
line_i  input  LINE_W  write line from upstream.
line_o  output  LINE_W  assembled read line to upstream.
address_i  input  32  line address from upstream.
read_i  input  1  upstream line read request, held until resp_o.
write_i  input  1  upstream line write request, held until resp_o.
resp_o  output  1  one-cycle completion pulse to upstream.
burst_i  input  BURST_W  read beat from memory.
burst_o  output  BURST_W  write beat to memory.
address_o  output  32  line-aligned burst address to memory.
read_o  output  1  burst read request.
write_o  output  1  burst write request.
resp_i  input  1  memory beat strobe: one beat transferred per cycle high.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, beat counter=0, line buffer=0, latched address=0.
  - resp_o, read_o, write_o = 0; burst_o, address_o, line_o = 0.
  - Reset mid-burst abandons the burst immediately; nothing completes.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - read_i=1: latch {address_i[31:5],5'b0}, cnt=0, go RD.
  - Else write_i=1: latch aligned address and line_i, cnt=0, go WR.
  - read_i and write_i both high: read wins; write stays pending and is served on a later IDLE cycle.
  - resp_i is ignored.
- RD:
  - read_o=1; address_o=latched address.
  - Each cycle with resp_i=1: buffer[cnt*64 +: 64] <= burst_i; cnt++.
  - Beat 0 maps to bits [63:0].
  - resp_i=1 with cnt==BEATS-1: go DONE.
  - read_o stays high until the final beat is accepted.
- WR:
  - write_o=1; address_o=latched address; burst_o=buffer[cnt*64 +: 64] combinationally.
  - Each cycle with resp_i=1: cnt++.
  - On the final beat: go DONE.
  - Gaps (resp_i=0) hold cnt and burst_o stable.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0; go IDLE.
- line_o is driven from the buffer at all times; it is valid in DONE following a read. After a write, line_o equals the written line.
- address_o is 0 in IDLE and DONE.
- Latency:
  - Request seen in IDLE cycle 0 → RD/WR from cycle 1.
  - With back-to-back resp_i on cycles 1-4, resp_o is high on cycle 5.
  - Each resp_i gap cycle adds one cycle.
- Counter is log2(BEATS) bits; it wraps to 0 on the final beat.
- Upstream drops its request the cycle after resp_o, so IDLE does not re-trigger.

Optional Feature:
ADAPTOR_TIMEOUT_EN
- Defined:
  - Adds output err_o (1 bit, reset 0) and a stall counter.
  - The stall counter clears on every resp_i and on entry to RD/WR.
  - It increments each RD/WR cycle with resp_i=0.
  - On reaching TIMEOUT_CYCLES: go DONE, pulse resp_o with err_o=1 for the same single cycle.
  - Buffer contents after a timeout are undefined to upstream.
- Undefined: no err_o port, no counter; the adaptor waits indefinitely for resp_i.

Test Plan:
- Read, contiguous beats: read_i, address_i=0x0000_1234; resp_i on cycles 1-4 with burst_i=0x11..11, 0x22..22, 0x33..33, 0x44..44 → address_o=0x0000_1220; resp_o on cycle 5 only; line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write with gaps: write_i, line_i={D3,D2,D1,D0}; resp_i pattern 1,0,1,0,0,1,1 → burst_o holds D1 through its gap; write_o high 7 cycles; one resp_o pulse after the last beat.
- Simultaneous read_i=write_i=1: read burst first with resp_o; then upstream drops read_i → write burst follows starting from IDLE.
- Async reset asserted after beat 2 of a read → all outputs 0 immediately, without a clock edge; next read_i starts at beat 0 with a fresh buffer.
- Spurious resp_i=1 in IDLE for 3 cycles → no state change, no resp_o, buffer unchanged.
- With ADAPTOR_TIMEOUT_EN and TIMEOUT_CYCLES=8: read, no resp_i → resp_o=err_o=1 on the 9th cycle after the request; then IDLE.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//
// Bridges one 256-bit cache-line request from the eviction write buffer to a
// 4-beat 64-bit burst on the physical memory bus, then returns a single
// line-wide completion pulse upstream. One transaction in flight at a time.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   line_i     write line from upstream
//   line_o     assembled read line to upstream (driven from the line buffer)
//   address_i  line address from upstream
//   read_i     upstream line read request (held until resp_o)
//   write_i    upstream line write request (held until resp_o)
//   resp_o     one-cycle completion pulse to upstream
//   burst_i    read beat from memory
//   burst_o    write beat to memory
//   address_o  line-aligned burst address to memory (0 when not bursting)
//   read_o     burst read request
//   write_o    burst write request
//   resp_i     memory beat strobe, one beat per cycle high
//   err_o      timeout flag, valid with resp_o (only with ADAPTOR_TIMEOUT_EN)
//   state      current FSM state, for debug observation
//
// Optional feature macro: ADAPTOR_TIMEOUT_EN adds err_o and a stall counter
// that aborts a burst after TIMEOUT_CYCLES consecutive idle beats.
//
// Handshake: upstream raises read_i or write_i and holds it (with address_i
// and line_i stable) until it sees resp_o, then drops it the following cycle.
// Downstream, read_o/write_o stay high for the whole burst; each cycle with
// resp_i high moves exactly one beat, and gaps simply stall the burst.

module cacheline_adaptor #(
    parameter int LINE_W         = 256,
    parameter int BURST_W        = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i,
`ifdef ADAPTOR_TIMEOUT_EN
    output logic               err_o,
`endif
    output logic [1:0]         state
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);

    // A line is 32 bytes, so the burst address drops the low five bits.
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFE0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    if (BEATS < 2 || BEATS * BURST_W != LINE_W || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("cacheline_adaptor: LINE_W must be an exact multiple (>=2x) of BURST_W, TIMEOUT_CYCLES >= 1");
    end

    logic [LINE_W-1:0] buffer;
    logic [31:0]       addr_q;
    logic [CNT_W-1:0]  cnt;
    logic              last_beat;
    logic              timeout_hit;

    assign last_beat = (cnt == CNT_W'(BEATS - 1));

`ifdef ADAPTOR_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_q;
    logic               err_q;

    // Fires on the idle cycle that would bring the stall count up to the limit.
    assign timeout_hit = (state == S_RD || state == S_WR) && !resp_i &&
                         (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if ((state == S_RD || state == S_WR) && !resp_i) begin
                stall_q <= stall_q + STALL_W'(1);
            end else begin
                // Cleared by every beat and on every entry into a burst.
                stall_q <= '0;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (state == S_DONE) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err_o = err_q && (state == S_DONE);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            buffer <= '0;
            addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Read wins a tie; the held write is picked up on a later
                    // IDLE cycle once upstream drops read_i.
                    if (read_i) begin
                        addr_q <= address_i & ALIGN_MASK;
                        cnt    <= '0;
                        state  <= S_RD;
                    end else if (write_i) begin
                        addr_q <= address_i & ALIGN_MASK;
                        buffer <= line_i;
                        cnt    <= '0;
                        state  <= S_WR;
                    end
                end
                S_RD: begin
                    if (resp_i) begin
                        buffer[int'(cnt) * BURST_W +: BURST_W] <= burst_i;
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (timeout_hit) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end
                end
                S_WR: begin
                    if (resp_i) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (timeout_hit) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs decode directly from state so an asynchronous reset clears
    // them without waiting for a clock edge.
    assign read_o    = (state == S_RD);
    assign write_o   = (state == S_WR);
    assign resp_o    = (state == S_DONE);
    assign address_o = (state == S_RD || state == S_WR) ? addr_q : 32'd0;
    assign burst_o   = (state == S_WR) ? buffer[int'(cnt) * BURST_W +: BURST_W] : '0;
    assign line_o    = buffer;

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;

  logic               clk;
  logic               rst;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;
  logic [1:0]         state;
`ifdef ADAPTOR_TIMEOUT_EN
  logic               err_o;
`endif

  cacheline_adaptor #(
    .LINE_W(LINE_W),
    .BURST_W(BURST_W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .line_i(line_i),
    .line_o(line_o),
    .address_i(address_i),
    .read_i(read_i),
    .write_i(write_i),
    .resp_o(resp_o),
    .burst_i(burst_i),
    .burst_o(burst_o),
    .address_o(address_o),
    .read_o(read_o),
    .write_o(write_o),
    .resp_i(resp_i),
`ifdef ADAPTOR_TIMEOUT_EN
    .err_o(err_o),
`endif
    .state(state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [LINE_W-1:0] exp_q[$];
  logic [LINE_W-1:0] last_line;

  typedef struct {
    logic              rd;
    logic              wr;
    logic [31:0]       addr;
    logic [LINE_W-1:0] wline;
    logic [LINE_W-1:0] rbeats;
    int                npat;
    logic [31:0]       pat;       // bit k-1 = resp_i in burst cycle k
    logic [31:0]       exp_addr;
    int                exp_resp;  // cycle (after request cycle 0) with resp_o
    logic [LINE_W-1:0] exp_line;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // ---------------- driver ----------------
  // Cycle 0 presents the request (this also drops the previous one); cycles
  // 1..exp_resp drive the strobe pattern and check the burst and completion.
  task automatic run_txn(input vec_t v, input string tag);
    int nb;
    logic [LINE_W-1:0] exp_l;
    nb = 0;
    @(posedge clk); #1;
    read_i    = v.rd;
    write_i   = v.wr;
    address_i = v.addr;
    line_i    = v.wline;
    resp_i    = 1'b0;
    burst_i   = rand64();
    exp_q.push_back(v.exp_line);
    @(negedge clk);
    check({tag, " idle read_o"}, read_o, 0);
    check({tag, " idle write_o"}, write_o, 0);
    check({tag, " idle resp_o"}, resp_o, 0);
    check({tag, " idle address_o"}, address_o, 0);
    for (int k = 1; k <= v.exp_resp; k++) begin
      @(posedge clk); #1;
      resp_i  = (k <= v.npat) ? v.pat[k-1] : 1'b0;
      burst_i = resp_i ? v.rbeats[nb*BURST_W +: BURST_W] : rand64();
      @(negedge clk);
      if (k < v.exp_resp) begin
        check({tag, " burst read_o"}, read_o, v.rd);
        check({tag, " burst write_o"}, write_o, !v.rd);
        check({tag, " burst resp_o"}, resp_o, 0);
        check({tag, " burst address_o"}, address_o, v.exp_addr);
        if (!v.rd) check({tag, " burst_o"}, burst_o, v.wline[nb*BURST_W +: BURST_W]);
      end else begin
        check({tag, " done resp_o"}, resp_o, 1);
        check({tag, " done read_o"}, read_o, 0);
        check({tag, " done write_o"}, write_o, 0);
        check({tag, " done address_o"}, address_o, 0);
`ifdef ADAPTOR_TIMEOUT_EN
        check({tag, " done err_o"}, err_o, 0);
`endif
        exp_l = exp_q.pop_front();
        check({tag, " line_o"}, line_o, exp_l);
        last_line = exp_l;
      end
      if (resp_i) nb++;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    read_i  = 1'b0;
    write_i = 1'b0;
    resp_i  = 1'b0;
  endtask

  // ---------------- reference model for random transactions ----------------
  // Transaction-level: the strobe pattern decides when the fourth beat lands,
  // completion follows one cycle later, and the line is either the beats in
  // arrival order (read) or the line that was written.
  function automatic vec_t make_random();
    vec_t v;
    int strobes;
    int gaps;
    v.rd     = ($urandom_range(0, 1) == 1);
    v.wr     = !v.rd;
    v.addr   = $urandom;
    v.wline  = rand_line();
    v.rbeats = rand_line();
    v.pat    = '0;
    v.npat   = 0;
    strobes  = 0;
    gaps     = 0;
    while (strobes < LINE_W / BURST_W) begin
      if (gaps < 3 && $urandom_range(0, 2) == 0) begin
        gaps++;
      end else begin
        v.pat[v.npat] = 1'b1;
        strobes++;
        gaps = 0;
      end
      v.npat++;
    end
    v.exp_addr = {v.addr[31:5], 5'b0};
    v.exp_resp = v.npat + 1;
    v.exp_line = v.rd ? v.rbeats : v.wline;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [LINE_W-1:0] d_line;
    logic [LINE_W-1:0] r_line;
    vec_t rv;

    d_line = {{4{16'hD3D3}}, {4{16'hD2D2}}, {4{16'hD1D1}}, {4{16'hD0D0}}};
    r_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};

    vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1234, wline: '0, rbeats: r_line,
                npat: 4, pat: 32'b1111, exp_addr: 32'h0000_1220, exp_resp: 5, exp_line: r_line};
    vecs[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'hABCD_EF7F, wline: d_line, rbeats: '0,
                npat: 7, pat: 32'b1100101, exp_addr: 32'hABCD_EF60, exp_resp: 8, exp_line: d_line};
    vecs[2] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_0040, wline: ~d_line, rbeats: ~r_line,
                npat: 4, pat: 32'b1111, exp_addr: 32'h0000_0040, exp_resp: 5, exp_line: ~r_line};
    vecs[3] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0040, wline: ~d_line, rbeats: '0,
                npat: 4, pat: 32'b1111, exp_addr: 32'h0000_0040, exp_resp: 5, exp_line: ~d_line};
    vecs[4] = '{rd: 1'b1, wr: 1'b0, addr: 32'hFFFF_FFFF, wline: '0, rbeats: d_line ^ r_line,
                npat: 6, pat: 32'b111100, exp_addr: 32'hFFFF_FFE0, exp_resp: 7, exp_line: d_line ^ r_line};

    // reset block
    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0; last_line = '0;
    #3;
    check("reset read_o", read_o, 0);
    check("reset write_o", write_o, 0);
    check("reset resp_o", resp_o, 0);
    check("reset address_o", address_o, 0);
    check("reset burst_o", burst_o, 0);
    check("reset line_o", line_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // table-driven vectors (vecs[2]/vecs[3] form the read-wins-tie pair)
    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // spurious strobes in IDLE
    idle_cycle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      resp_i  = 1'b1;
      burst_i = rand64();
      @(negedge clk);
      check("spurious read_o", read_o, 0);
      check("spurious write_o", write_o, 0);
      check("spurious resp_o", resp_o, 0);
      check("spurious line_o", line_o, last_line);
    end
    idle_cycle();

    // async reset after two beats of a read
    @(posedge clk); #1;
    read_i = 1'b1; address_i = 32'h0000_2000;
    @(posedge clk); #1; resp_i = 1'b1; burst_i = {4{16'hAAAA}};
    @(posedge clk); #1; resp_i = 1'b1; burst_i = {4{16'hBBBB}};
    @(posedge clk); #1; resp_i = 1'b0; read_i = 1'b0;
    @(negedge clk);
    check("mid-read line_o before reset", line_o[127:0], {{4{16'hBBBB}}, {4{16'hAAAA}}});
    #2; rst = 1'b0; #1;
    check("async rst read_o", read_o, 0);
    check("async rst address_o", address_o, 0);
    check("async rst line_o", line_o, 0);
    check("async rst resp_o", resp_o, 0);
    @(negedge clk);
    rst = 1'b1;
    rv = make_random();
    rv.rd = 1'b1; rv.wr = 1'b0; rv.exp_line = rv.rbeats;
    run_txn(rv, "post-reset read");

    // randomized transactions against the model
    for (int i = 0; i < 20; i++) begin
      rv = make_random();
      run_txn(rv, $sformatf("rand%0d", i));
    end
    idle_cycle();

`ifdef ADAPTOR_TIMEOUT_EN
    @(posedge clk); #1;
    read_i = 1'b1; address_i = 32'h0000_3000;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      resp_i = 1'b0;
      @(negedge clk);
      if (k < 9) begin
        check("timeout waiting read_o", read_o, 1);
        check("timeout waiting resp_o", resp_o, 0);
      end else begin
        check("timeout resp_o", resp_o, 1);
        check("timeout err_o", err_o, 1);
      end
    end
    @(posedge clk); #1; read_i = 1'b0;
    @(negedge clk);
    check("after timeout resp_o", resp_o, 0);
    check("after timeout err_o", err_o, 0);
    check("after timeout read_o", read_o, 0);
`endif

    check("scoreboard drained", exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
